// File: rtl/ofmap_acc_pkg.sv
// Shared types and helpers for the ofmap accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ofmap_acc_pkg;

    localparam int LANE_W       = 32;
    localparam int PKG_MAC_COL  = 16;
    localparam int PKG_ADDR_BIT = 10;

    // One accumulation pipeline stage: control tag plus a full de-skewed row.
    typedef struct packed {
        logic                            valid;
        logic                            clear;
        logic                            last;
        logic [PKG_ADDR_BIT-1:0]         addr;
        logic [PKG_MAC_COL*LANE_W-1:0]   data;
    } stage_t;

    function automatic logic [LANE_W-1:0] lane_of(
        input logic [PKG_MAC_COL*LANE_W-1:0] vec,
        input int                            idx
    );
        return vec[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to line up skewed array columns.
// Latency: DEPTH cycles (DEPTH >= 1).
// Backpressure: none; shifts every cycle.
module skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ofmap_accumulator.sv
// De-skews systolic psum columns and read-modify-write accumulates rows into the ofmap SRAM.
// Latency: MAC_COL+2 cycles from column-0 valid to SRAM write; done one cycle after the last write.
// Backpressure: none; accepts one vector per cycle, bubbles flow through as invalid stages.
module ofmap_accumulator
    import ofmap_acc_pkg::*;
#(
    parameter int MAC_COL        = PKG_MAC_COL,
    parameter int OFMAP_BITWIDTH = LANE_W,
    parameter int OFMAP_ADDR_BIT = PKG_ADDR_BIT
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              psum_valid_in,
    input  logic [OFMAP_ADDR_BIT-1:0]         psum_addr_in,
    input  logic                              psum_clear_in,
    input  logic                              psum_last_in,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] psum_in,
    output logic                              mem_rd_en_out,
    output logic [OFMAP_ADDR_BIT-1:0]         mem_rd_addr_out,
    input  logic [MAC_COL*OFMAP_BITWIDTH-1:0] mem_rd_data_in,
    output logic                              mem_wr_en_out,
    output logic [OFMAP_ADDR_BIT-1:0]         mem_wr_addr_out,
    output logic [MAC_COL*OFMAP_BITWIDTH-1:0] mem_wr_data_out,
    output logic                              busy_out,
    output logic                              done_out
);

    localparam int W     = OFMAP_BITWIDTH;
    localparam int DW    = MAC_COL * OFMAP_BITWIDTH;
    localparam int TAG_W = OFMAP_ADDR_BIT + 3;
    localparam int CNT_W = $clog2(MAC_COL) + 1;

    logic [TAG_W-1:0]          tag_d;
    logic [DW-1:0]             deskew;
    logic [CNT_W-1:0]          skew_cnt;
    stage_t                    a_q;
    stage_t                    b_q;
    logic                      c_vld;
    logic                      c_last;
    logic [OFMAP_ADDR_BIT-1:0] c_addr;
    logic [DW-1:0]             c_dat;
    logic                      d_vld;
    logic [OFMAP_ADDR_BIT-1:0] d_addr;
    logic [DW-1:0]             d_dat;
    logic                      done_q;
    logic [DW-1:0]             old_dat;
    logic [DW-1:0]             sum_dat;

    // Tag bit order: {addr, clear, last, valid}.
    skew_delay_line #(
        .DEPTH (MAC_COL - 1),
        .WIDTH (TAG_W)
    ) u_tag_dly (
        .clk  (clk),
        .rstn (rstn),
        .din  ({psum_addr_in, psum_clear_in, psum_last_in, psum_valid_in}),
        .dout (tag_d)
    );

    for (genvar c = 0; c < MAC_COL; c++) begin : g_lane
        if (c == MAC_COL - 1) begin : g_direct
            assign deskew[c*W +: W] = psum_in[c*W +: W];
        end else begin : g_skew
            skew_delay_line #(
                .DEPTH (MAC_COL - 1 - c),
                .WIDTH (W)
            ) u_lane_dly (
                .clk  (clk),
                .rstn (rstn),
                .din  (psum_in[c*W +: W]),
                .dout (deskew[c*W +: W])
            );
        end
    end

    // Occupancy of the tag line, so busy covers vectors still being de-skewed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skew_cnt <= '0;
        end else begin
            case ({psum_valid_in, tag_d[0]})
                2'b10:   skew_cnt <= skew_cnt + 1'b1;
                2'b01:   skew_cnt <= skew_cnt - 1'b1;
                default: skew_cnt <= skew_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q.valid <= tag_d[0];
            a_q.last  <= tag_d[1];
            a_q.clear <= tag_d[2];
            a_q.addr  <= tag_d[TAG_W-1:3];
            a_q.data  <= deskew;
            b_q       <= a_q;
        end
    end

    // C holds the newest in-flight value, D covers the read-old-data write collision.
    always_comb begin
        old_dat = mem_rd_data_in;
        if (c_vld && (c_addr == b_q.addr)) begin
            old_dat = c_dat;
        end else if (d_vld && (d_addr == b_q.addr)) begin
            old_dat = d_dat;
        end
    end

    always_comb begin
        sum_dat = '0;
        for (int c = 0; c < MAC_COL; c++) begin
            sum_dat[c*W +: W] = b_q.clear ? lane_of(b_q.data, c)
                                          : lane_of(old_dat, c) + lane_of(b_q.data, c);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_vld  <= 1'b0;
            c_last <= 1'b0;
            c_addr <= '0;
            c_dat  <= '0;
            d_vld  <= 1'b0;
            d_addr <= '0;
            d_dat  <= '0;
            done_q <= 1'b0;
        end else begin
            c_vld  <= b_q.valid;
            c_last <= b_q.last;
            c_addr <= b_q.addr;
            c_dat  <= sum_dat;
            d_vld  <= c_vld;
            d_addr <= c_addr;
            d_dat  <= c_dat;
            done_q <= c_vld & c_last;
        end
    end

    assign mem_rd_en_out   = a_q.valid & ~a_q.clear;
    assign mem_rd_addr_out = a_q.addr;
    assign mem_wr_en_out   = c_vld;
    assign mem_wr_addr_out = c_addr;
    assign mem_wr_data_out = c_dat;
    assign done_out        = done_q;
    assign busy_out        = (skew_cnt != '0) | a_q.valid | b_q.valid | c_vld | d_vld;

endmodule

// File: tb/tb_ofmap_accumulator.sv
// Scoreboard bench for ofmap_accumulator with a behavioural 1-cycle-latency SRAM.
module tb_ofmap_accumulator;

    localparam int NC = 16;
    localparam int W  = 32;
    localparam int AW = 10;
    localparam int DW = NC * W;

    logic          clk = 1'b0;
    logic          rstn;
    logic          psum_valid_in;
    logic [AW-1:0] psum_addr_in;
    logic          psum_clear_in;
    logic          psum_last_in;
    logic [DW-1:0] psum_in;
    logic          mem_rd_en_out;
    logic [AW-1:0] mem_rd_addr_out;
    logic [DW-1:0] mem_rd_data_in;
    logic          mem_wr_en_out;
    logic [AW-1:0] mem_wr_addr_out;
    logic [DW-1:0] mem_wr_data_out;
    logic          busy_out;
    logic          done_out;

    always #5 clk = ~clk;

    ofmap_accumulator dut (
        .clk             (clk),
        .rstn            (rstn),
        .psum_valid_in   (psum_valid_in),
        .psum_addr_in    (psum_addr_in),
        .psum_clear_in   (psum_clear_in),
        .psum_last_in    (psum_last_in),
        .psum_in         (psum_in),
        .mem_rd_en_out   (mem_rd_en_out),
        .mem_rd_addr_out (mem_rd_addr_out),
        .mem_rd_data_in  (mem_rd_data_in),
        .mem_wr_en_out   (mem_wr_en_out),
        .mem_wr_addr_out (mem_wr_addr_out),
        .mem_wr_data_out (mem_wr_data_out),
        .busy_out        (busy_out),
        .done_out        (done_out)
    );

    // SRAM model: read returns the pre-write contents on a same-cycle collision.
    logic [DW-1:0] mem [1024];
    always @(posedge clk) begin
        if (mem_rd_en_out) mem_rd_data_in <= mem[mem_rd_addr_out];
        if (mem_wr_en_out) mem[mem_wr_addr_out] <= mem_wr_data_out;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
        int            cyc;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        int            cyc;
    } rd_t;

    wr_t         exp_q[$];
    rd_t         rd_q[$];
    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_due = -1;
    logic [31:0] ring [32][NC];
    bit          rset [32][NC];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input int base, input int inc);
        logic [DW-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c*W +: W] = 32'(base + inc * c);
        return v;
    endfunction

    // One input cycle: schedule a new vector's lanes on their skewed cycles, drive this cycle.
    task automatic step(input bit v, input logic [AW-1:0] a, input bit clr, input bit lst,
                        input logic [DW-1:0] vec);
        int s;
        if (v) begin
            for (int c = 0; c < NC; c++) begin
                s = (cyc + c) % 32;
                ring[s][c] = vec[c*W +: W];
                rset[s][c] = 1'b1;
            end
        end
        psum_valid_in = v;
        psum_addr_in  = a;
        psum_clear_in = clr;
        psum_last_in  = lst;
        s = cyc % 32;
        for (int c = 0; c < NC; c++) begin
            if (rset[s][c]) begin
                psum_in[c*W +: W] = ring[s][c];
                rset[s][c] = 1'b0;
            end else begin
                psum_in[c*W +: W] = $urandom;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic issue(input logic [AW-1:0] a, input bit clr, input bit lst,
                         input logic [DW-1:0] vec, input logic [DW-1:0] expv);
        wr_t w;
        rd_t r;
        w.addr = a;
        w.data = expv;
        w.last = lst;
        w.cyc  = cyc + 18;
        exp_q.push_back(w);
        if (!clr) begin
            r.addr = a;
            r.cyc  = cyc + 16;
            rd_q.push_back(r);
        end
        step(1'b1, a, clr, lst, vec);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctrl"},
            DW'({mem_rd_en_out, mem_rd_addr_out, mem_wr_en_out, mem_wr_addr_out, busy_out, done_out}),
            '0);
        chk({tag, "_wr_data"}, mem_wr_data_out, '0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read or a write.
    always @(negedge clk) begin : mon
        rd_t r;
        wr_t w;
        if (!rstn) begin
            exp_q.delete();
            rd_q.delete();
            done_due = -1;
        end else begin
            if (mem_rd_en_out) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rd_unexpected: read addr %0d at cycle %0d, none required",
                             mem_rd_addr_out, cyc);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_addr", DW'(mem_rd_addr_out), DW'(r.addr));
                    chk("rd_cycle", DW'(cyc), DW'(r.cyc));
                end
            end
            if (mem_wr_en_out) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL wr_unexpected: write addr %0d at cycle %0d, none required",
                             mem_wr_addr_out, cyc);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", DW'(mem_wr_addr_out), DW'(w.addr));
                    chk("wr_data", mem_wr_data_out, w.data);
                    chk("wr_cycle", DW'(cyc), DW'(w.cyc));
                    if (w.last) done_due = cyc + 1;
                end
            end
            if (done_out || (cyc == done_due)) begin
                chk("done", DW'(done_out), DW'(cyc == done_due));
            end
        end
    end

    initial begin : stim
        logic [DW-1:0] v;
        logic [DW-1:0] o;
        logic [DW-1:0] e;
        int            k;
        rstn          = 1'b0;
        psum_valid_in = 1'b0;
        psum_addr_in  = '0;
        psum_clear_in = 1'b0;
        psum_last_in  = 1'b0;
        psum_in       = '0;
        for (int i = 0; i < 1024; i++) mem[i] = {NC{32'h0BAD0BAD}};
        #12;
        chk_idle("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc  = 0;

        // Clear writes to rows 0..3, lane c = 100*addr + c.
        for (int a = 0; a < 4; a++) issue(AW'(a), 1'b1, a == 3, fill(100 * a, 1), fill(100 * a, 1));
        idle(22);

        // Accumulate onto a row preset to 5.
        mem[20] = fill(5, 0);
        issue(10'd20, 1'b0, 1'b1, fill(0, 1), fill(5, 1));
        idle(22);

        // Back-to-back hits: row 7 via C forwarding, row 8 via D forwarding.
        mem[7] = {NC{32'h00000055}};
        mem[8] = {NC{32'h0000DEAD}};
        issue(10'd7, 1'b1, 1'b0, fill(1, 0), fill(1, 0));
        issue(10'd7, 1'b0, 1'b0, fill(1, 0), fill(2, 0));
        issue(10'd7, 1'b0, 1'b0, fill(1, 0), fill(3, 0));
        issue(10'd8, 1'b1, 1'b0, fill(10, 0), fill(10, 0));
        issue(10'd9, 1'b1, 1'b0, fill(20, 0), fill(20, 0));
        issue(10'd8, 1'b0, 1'b1, fill(1, 0), fill(11, 0));
        idle(22);

        // Wrap-around, negative operands and carry isolation between lanes.
        v = '0; v[31:0] = 32'd1;         v[63:32] = 32'd3;         v[95:64] = 32'd1;         v[127:96] = 32'd7;
        o = '0; o[31:0] = 32'h7FFFFFFF;  o[63:32] = 32'hFFFFFFFB;  o[95:64] = 32'hFFFFFFFF;
        e = '0; e[31:0] = 32'h80000000;  e[63:32] = 32'hFFFFFFFE;  e[95:64] = 32'h0;         e[127:96] = 32'd7;
        mem[30] = o;
        issue(10'd30, 1'b0, 1'b1, v, e);
        idle(22);

        // Alternate-cycle valids with random filler on unused skew slots.
        k = 0;
        for (int i = 0; i < 4; i++) begin
            k = cyc;
            issue(AW'(40 + i), 1'b1, i == 3, fill(1000 * i, 1), fill(1000 * i, 1));
            if (i < 3) idle(1);
        end
        idle(k + 19 - cyc);
        chk("busy_after_last_write", DW'(busy_out), DW'(1));
        idle(1);
        chk("busy_drop", DW'(busy_out), DW'(0));
        idle(4);

        // Reset while three vectors are still in the skew line.
        for (int i = 0; i < 3; i++) issue(AW'(50 + i), 1'b1, i == 2, fill(7, 1), fill(7, 1));
        idle(2);
        rstn = 1'b0;
        #2;
        chk_idle("mid_reset");
        idle(2);
        rstn = 1'b1;
        idle(30);
        chk("post_reset_ctrl", DW'({mem_rd_en_out, mem_wr_en_out, busy_out, done_out}), '0);

        chk("scoreboard_drained", DW'(exp_q.size() + rd_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ofmap_accumulator.md
Name: ofmap_accumulator

Overview:
- Downstream stage of the systolic MAC array.
- Takes the column-skewed partial-sum vectors leaving the bottom of the array and de-skews them into full MAC_COL-wide rows.
- Performs read-modify-write accumulation into the ofmap SRAM (one MAC_COL*OFMAP_BITWIDTH word per output pixel), with forwarding so back-to-back hits on the same address are accumulated correctly.
- Signals completion when the tagged last vector has been written.

Parameters:
MAC_COL, 16, number of array columns / lanes per ofmap word
OFMAP_BITWIDTH, 32, bits per lane (signed two's complement)
OFMAP_ADDR_BIT, 10, ofmap SRAM address width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
psum_valid_in  in  1  column-0 psum valid; column c data is valid exactly c cycles later
psum_addr_in  in  OFMAP_ADDR_BIT  ofmap address, sampled with psum_valid_in
psum_clear_in  in  1  1 = overwrite (first channel tile), 0 = accumulate; sampled with psum_valid_in
psum_last_in  in  1  marks the final vector of the job; sampled with psum_valid_in
psum_in  in  MAC_COL*OFMAP_BITWIDTH  lane c = bits [32c+31:32c], skewed by c cycles
mem_rd_en_out  out  1  SRAM read enable (1-cycle read latency)
mem_rd_addr_out  out  OFMAP_ADDR_BIT  SRAM read address
mem_rd_data_in  in  MAC_COL*OFMAP_BITWIDTH  SRAM read data, valid the cycle after mem_rd_en_out
mem_wr_en_out  out  1  SRAM write enable
mem_wr_addr_out  out  OFMAP_ADDR_BIT  SRAM write address
mem_wr_data_out  out  MAC_COL*OFMAP_BITWIDTH  SRAM write data
busy_out  out  1  any pipeline stage holds a valid vector
done_out  out  1  one-cycle pulse after the last-tagged vector is written

Behaviour:
- Reset (async, rstn=0): every valid bit, tag and skew register is cleared. All outputs are 0. Reset mid-job discards all in-flight vectors; no write is issued afterwards.
- De-skew:
  - Lane c is delayed MAC_COL-1-c cycles (lane MAC_COL-1 has no delay).
  - valid/addr/clear/last are delayed MAC_COL-1 cycles.
  - All of the above are then registered into stage A.
  - Column-0 valid at cycle T puts a complete vector in stage A at T+MAC_COL.
- Stage A (cycle T+MAC_COL): mem_rd_en_out=1, mem_rd_addr_out=A.addr, driven combinationally from stage A. Skipped when A.clear=1, since the old value is unused.
- Stage B (T+MAC_COL+1), choice of old value:
  - if C.valid and C.addr==B.addr, use C.data;
  - else if D.valid and D.addr==B.addr, use D.data;
  - else use mem_rd_data_in.
- Stage B sum, registered into C:
  - If B.clear: sum = psum.
  - Otherwise: sum = old + psum per lane, 32-bit modulo add, wrap-around, no saturation.
- Stage C (T+MAC_COL+2): mem_wr_en_out=1, mem_wr_addr_out=C.addr, mem_wr_data_out=C.data. Total latency = MAC_COL+2 cycles from column-0 valid to write.
- Stage D: copy of C's addr/data/valid, delayed one cycle. It covers the SRAM read-old-data collision, where a read and a write to the same address fall in the same cycle.
- Forwarding priority is C over D (C is newer).
- Throughput: one vector per cycle, no backpressure. Bubbles (psum_valid_in=0) propagate as invalid stages.
- done_out pulses in the cycle after stage C writes a vector with last=1. A later job may start immediately.
- busy_out = OR of all valid bits in the skew line and stages A–D.
- Lanes whose skewed data arrives while the corresponding valid is 0 are don't-care; they are never written.

Decomposition:
- Package ofmap_acc_pkg:
  - lane width constant;
  - stage struct typedef {valid, clear, last, addr, data};
  - lane-slice helper function.
- Sub-module skew_delay_line (parameterised depth/width shift register with async reset), instantiated per lane and for the control tag. Everything else lives in the top module.

Test Plan:
- Clear write: 4 vectors with clear=1 to addr 0..3, lane c value = 100*addr+c → SRAM rows match; first write 18 cycles after first valid; done_out 1 cycle after addr 3 written.
- Accumulate: SRAM preset to 5 in all lanes; one vector with clear=0, lanes=c → written lanes = 5+c; mem_rd_en_out seen exactly 16 cycles after valid.
- Forwarding: addr 7 sent on 3 consecutive cycles, clear then accumulate twice, each lane = 1 → final row 7 lanes = 3 (exercises C and D paths).
- Wrap and sign: old lane = 0x7FFFFFFF, psum = 1 → 0x80000000; old = -5, psum = 3 → -2.
- Bubbles and skew: valid on alternate cycles, lane c data driven only in its skewed cycle (other cycles random) → correct rows written; busy_out drops 2 cycles after the last write.
- Reset mid-job: assert rstn=0 while 3 vectors are in the skew line → no mem_wr_en_out and no done_out afterwards; all outputs 0 during reset.
